// File: rtl/div_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : div_sequencer_if                                                |
// | Brief  : EX-stage request, HI/LO access and divide-core bundle            |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             flush;
  logic             rd_req;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;

  modport slave (
    input  op_valid, op_signed, op_a, op_b, flush, rd_req, wr_hi, wr_lo, wr_data,
           core_q, core_r,
    output op_ready, stall, busy, done, div0, hi, lo, core_a, core_b, core_load,
           core_step
  );

  modport master (
    output op_valid, op_signed, op_a, op_b, flush, rd_req, wr_hi, wr_lo, wr_data,
           core_q, core_r,
    input  op_ready, stall, busy, done, div0, hi, lo, core_a, core_b, core_load,
           core_step
  );
endinterface
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : div_sequencer                                                   |
// | Brief  : Sequences a shared radix-2 restoring divide core; owns HI/LO     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      reset,
  div_sequencer_if.slave bus
);
  localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div0;

  logic               w_idle;
  logic               w_accept;
  logic               w_fix_commit;

  assign w_idle       = (r_state == IDLE);
  assign w_accept     = w_idle & bus.op_valid & ~bus.flush;
  assign w_fix_commit = (r_state == FIX) & ~bus.flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (bus.op_b == '0) ? FIX : LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (r_cnt == c_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.flush && !w_idle) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      if (w_idle) begin
        if (bus.wr_hi) r_hi <= bus.wr_data;
        if (bus.wr_lo) r_lo <= bus.wr_data;
        if (w_accept) begin
          r_neg_q <= bus.op_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          r_neg_r <= bus.op_signed & bus.op_a[WIDTH-1];
          r_dz    <= (bus.op_b == '0);
          r_mag_a <= (bus.op_signed & bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
          r_mag_b <= (bus.op_signed & bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        end
      end
      if (r_state == LOAD) r_cnt <= '0;
      if (r_state == RUN)  r_cnt <= r_cnt + c_cnt_w'(1);
      // Divide-by-zero re-applies the dividend sign, so hi returns the raw op_a.
      if (w_fix_commit) begin
        if (r_dz) begin
          r_lo <= '1;
          r_hi <= r_neg_r ? -r_mag_a : r_mag_a;
        end else begin
          r_lo <= r_neg_q ? -bus.core_q : bus.core_q;
          r_hi <= r_neg_r ? -bus.core_r : bus.core_r;
        end
        r_done <= 1'b1;
        r_div0 <= r_dz;
      end
    end
  end

  assign bus.op_ready  = w_idle;
  assign bus.busy      = ~w_idle;
  assign bus.stall     = (~w_idle & (bus.rd_req | bus.wr_hi | bus.wr_lo)) |
                         (bus.op_valid & ~w_idle);
  assign bus.core_load = (r_state == LOAD);
  assign bus.core_step = (r_state == RUN);
  assign bus.core_a    = r_mag_a;
  assign bus.core_b    = r_mag_b;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.done      = r_done;
  assign bus.div0      = r_div0;
endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_div_sequencer                                                |
// | Brief  : Directed bench with a restoring-divide core model               |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W)) bus();
  div_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Radix-2 restoring core: remainder shifts in dividend MSBs, quotient fills LSBs.
  logic [W-1:0] cq, cr, cb;
  logic [W:0]   trial;
  always @(posedge clk) begin
    if (bus.core_load) begin
      cq <= bus.core_a; cr <= '0; cb <= bus.core_b;
    end else if (bus.core_step) begin
      trial = {cr, cq[W-1]};
      if (trial >= {1'b0, cb}) begin
        cr <= W'(trial - {1'b0, cb}); cq <= {cq[W-2:0], 1'b1};
      end else begin
        cr <= trial[W-1:0];           cq <= {cq[W-2:0], 1'b0};
      end
    end
  end
  assign bus.core_q = cq;
  assign bus.core_r = cr;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int dcyc, output int loads, output int steps, output logic d0);
    dcyc = -1; loads = 0; steps = 0; d0 = 1'b0;
    bus.op_valid = 1'b1; bus.op_signed = sgn; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.core_load) loads++;
      if (bus.core_step) steps++;
      if (bus.done) begin dcyc = c; d0 = bus.div0; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_total++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) $display("FAIL reset_busy busy=%b ready=%b exp 0/1", bus.busy, bus.op_ready); else n_pass++;
    n_total++; if (bus.hi !== '0 || bus.lo !== '0) $display("FAIL reset_hilo hi=%h lo=%h exp 0/0", bus.hi, bus.lo); else n_pass++;
    n_total++; if ({bus.done, bus.div0, bus.core_load, bus.core_step, bus.stall} !== 5'b0) $display("FAIL reset_ctrl got=%b exp 00000", {bus.done, bus.div0, bus.core_load, bus.core_step, bus.stall}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL post_reset busy=%b done=%b exp 0/0", bus.busy, bus.done); else n_pass++;
  endtask

  task automatic test_divu();
    int dc, ld, st; logic d0;
    run_div(1'b0, 32'd100, 32'd7, dc, ld, st, d0);
    n_total++; if (dc !== 35) $display("FAIL divu_latency got=%0d exp 35", dc); else n_pass++;
    n_total++; if (ld !== 1 || st !== 32) $display("FAIL divu_core loads=%0d steps=%0d exp 1/32", ld, st); else n_pass++;
    n_total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || d0 !== 1'b0) $display("FAIL divu_100_7 lo=%h hi=%h div0=%b exp 0000000e/00000002/0", bus.lo, bus.hi, d0); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.done !== 1'b0) $display("FAIL done_pulse got=%b exp 0", bus.done); else n_pass++;
    run_div(1'b0, 32'hFFFFFFFF, 32'd2, dc, ld, st, d0);
    n_total++; if (bus.lo !== 32'h7FFFFFFF || bus.hi !== 32'd1) $display("FAIL divu_max lo=%h hi=%h exp 7fffffff/00000001", bus.lo, bus.hi); else n_pass++;
  endtask

  task automatic test_signed();
    int dc, ld, st; logic d0;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, dc, ld, st, d0);
    n_total++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) $display("FAIL div_m7_2 lo=%h hi=%h exp fffffffd/ffffffff", bus.lo, bus.hi); else n_pass++;
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, dc, ld, st, d0);
    n_total++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'd1) $display("FAIL div_7_m2 lo=%h hi=%h exp fffffffd/00000001", bus.lo, bus.hi); else n_pass++;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, dc, ld, st, d0);
    n_total++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'd0 || d0 !== 1'b0 || dc !== 35) $display("FAIL div_min_m1 lo=%h hi=%h div0=%b cyc=%0d exp 80000000/0/0/35", bus.lo, bus.hi, d0, dc); else n_pass++;
  endtask

  task automatic test_div0();
    int dc, ld, st; logic d0;
    run_div(1'b0, 32'd5, 32'd0, dc, ld, st, d0);
    n_total++; if (dc !== 2 || d0 !== 1'b1) $display("FAIL div0_timing cyc=%0d div0=%b exp 2/1", dc, d0); else n_pass++;
    n_total++; if (ld !== 0 || st !== 0) $display("FAIL div0_core loads=%0d steps=%0d exp 0/0", ld, st); else n_pass++;
    n_total++; if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFFFFFF) $display("FAIL div0_u hi=%h lo=%h exp 00000005/ffffffff", bus.hi, bus.lo); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.div0 !== 1'b0) $display("FAIL div0_pulse got=%b exp 0", bus.div0); else n_pass++;
    run_div(1'b1, 32'hFFFFFFFB, 32'd0, dc, ld, st, d0);
    n_total++; if (bus.hi !== 32'hFFFFFFFB || bus.lo !== 32'hFFFFFFFF || d0 !== 1'b1) $display("FAIL div0_s hi=%h lo=%h div0=%b exp fffffffb/ffffffff/1", bus.hi, bus.lo, d0); else n_pass++;
  endtask

  task automatic test_stall();
    int bad = 0;
    int dc = -1;
    @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h55;
    @(posedge clk); #1; bus.wr_lo = 1'b0;
    @(negedge clk);
    n_total++; if (bus.lo !== 32'h55) $display("FAIL mtlo got=%h exp 00000055", bus.lo); else n_pass++;
    bus.op_valid = 1'b1; bus.op_signed = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.rd_req = 1'b1; bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.busy && !bus.stall) bad++;
      if (bus.done) begin dc = c; break; end
    end
    n_total++; if (bad !== 0 || dc !== 35) $display("FAIL stall_busy missed=%0d done_cyc=%0d exp 0/35", bad, dc); else n_pass++;
    n_total++; if (bus.stall !== 1'b0 || bus.hi !== 32'd2) $display("FAIL stall_done stall=%b hi=%h exp 0/00000002", bus.stall, bus.hi); else n_pass++;
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.wr_hi = 1'b0;
    @(negedge clk);
    n_total++; if (bus.hi !== 32'h1234 || bus.lo !== 32'd14) $display("FAIL mthi_after hi=%h lo=%h exp 00001234/0000000e", bus.hi, bus.lo); else n_pass++;
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hAAAA;
    @(posedge clk); #1; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.op_valid = 1'b1; bus.op_signed = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1; bus.op_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        @(negedge clk); bus.op_valid = 1'b1; #1;
        n_total++; if (bus.stall !== 1'b1 || bus.op_ready !== 1'b0) $display("FAIL busy_req stall=%b ready=%b exp 1/0", bus.stall, bus.op_ready); else n_pass++;
        bus.op_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_total++; if (bus.core_step !== 1'b1) $display("FAIL run_c10 core_step=%b exp 1", bus.core_step); else n_pass++;
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'hAAAA || bus.lo !== 32'hAAAA) $display("FAIL flush_run busy=%b hi=%h lo=%h exp 0/0000aaaa/0000aaaa", bus.busy, bus.hi, bus.lo); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); if (bus.done || bus.div0) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL flush_nodone pulses=%0d exp 0", seen); else n_pass++;
    bus.op_valid = 1'b1; bus.flush = 1'b1; bus.op_b = 32'd3;
    @(posedge clk); #1; bus.op_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL flush_idle busy=%b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, ld, st; logic d0;
    run_div(1'b0, 32'd100, 32'd7, dc, ld, st, d0);
    n_total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) $display("FAIL b2b_first lo=%h hi=%h exp 0000000e/00000002", bus.lo, bus.hi); else n_pass++;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, dc, ld, st, d0);
    n_total++; if (dc !== 35 || bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) $display("FAIL b2b_second cyc=%0d lo=%h hi=%h exp 35/fffffffd/ffffffff", dc, bus.lo, bus.hi); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.op_valid = 1'b1; bus.op_signed = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1; bus.op_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; #1;
    n_total++; if (bus.busy !== 1'b0 || bus.core_step !== 1'b0 || bus.op_ready !== 1'b1) $display("FAIL rst_mid_ctrl busy=%b step=%b ready=%b exp 0/0/1", bus.busy, bus.core_step, bus.op_ready); else n_pass++;
    n_total++; if (bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0) $display("FAIL rst_mid_regs hi=%h lo=%h done=%b exp 0/0/0", bus.hi, bus.lo, bus.done); else n_pass++;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.flush = 1'b0; bus.rd_req = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    test_reset();
    test_divu();
    test_signed();
    test_div0();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
